// File: rtl/seq_cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, result flags, chunk count.
package seq_cmp_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } result_t;

  function automatic int nchunk(input int nb, input int cw);
    return nb / cw;
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational CW-bit unsigned compare of one operand chunk.
module chunk_cmp #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic          gt,
  output logic          eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle NB-bit magnitude comparator, CW bits per cycle, MSB chunk first.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first differing chunk instead of constant time.
module seq_mag_comparator
  import seq_cmp_pkg::*;
#(
  parameter int NB = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NB-1:0] A,
  input  logic [NB-1:0] B,
  input  logic          sign_mode,
  output logic          busy,
  output logic          done,
  output logic          G,
  output logic          E,
  output logic          L
);

  localparam int NCHUNK = nchunk(NB, CW);
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
  localparam logic [NB-1:0] MSB_MASK = NB'(1) << (NB - 1);

  if (((NB % CW) != 0) || (NB < CW)) begin : g_bad_cfg
    $error("seq_mag_comparator: NB must be a non-zero multiple of CW");
  end

  state_t        state;
  logic [NB-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic          decided, gt_q;
  logic          busy_q, done_q;
  result_t       res;

  logic [NB-1:0] a_sh, b_sh;
  logic [CW-1:0] a_chunk, b_chunk;
  logic          chunk_gt, chunk_eq;
  logic          decided_nxt, gt_nxt, last_chunk, finish;

  // Shifting the selected chunk up to the MSB end keeps the mux a single barrel shift.
  always_comb begin
    a_sh    = a_q << (int'(idx) * CW);
    b_sh    = b_q << (int'(idx) * CW);
    a_chunk = a_sh[NB-1 -: CW];
    b_chunk = b_sh[NB-1 -: CW];
  end

  chunk_cmp #(.CW(CW)) u_chunk_cmp (
    .a  (a_chunk),
    .b  (b_chunk),
    .gt (chunk_gt),
    .eq (chunk_eq)
  );

  assign decided_nxt = decided | ~chunk_eq;
  assign gt_nxt      = decided ? gt_q : chunk_gt;
  assign last_chunk  = (idx == LAST_IDX);

`ifdef SEQ_CMP_EARLY_EXIT_EN
  assign finish = last_chunk | ~chunk_eq;
`else
  assign finish = last_chunk;
`endif

  // Operands are sign-biased at capture, so the RUN loop only ever does unsigned compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      gt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= A ^ (sign_mode ? MSB_MASK : '0);
            b_q     <= B ^ (sign_mode ? MSB_MASK : '0);
            idx     <= '0;
            decided <= 1'b0;
            gt_q    <= 1'b0;
            res     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          idx     <= idx + 1'b1;
          decided <= decided_nxt;
          gt_q    <= gt_nxt;
          if (finish) begin
            res    <= '{g: decided_nxt & gt_nxt, e: ~decided_nxt, l: decided_nxt & ~gt_nxt};
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign G    = res.g;
  assign E    = res.e;
  assign L    = res.l;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator (NB=16, CW=4): directed table, handshake corners, random ops.
module tb_seq_mag_comparator;

  localparam int NB     = 16;
  localparam int CW     = 4;
  localparam int NCHUNK = NB / CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sign_mode = 1'b0;
  logic [NB-1:0] A = '0;
  logic [NB-1:0] B = '0;
  logic          busy, done, G, E, L;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  res;
    int          fd;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  seq_mag_comparator #(.NB(NB), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .sign_mode (sign_mode),
    .busy      (busy),
    .done      (done),
    .G         (G),
    .E         (E),
    .L         (L)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic, result packed as {G,E,L}.
  function automatic logic [2:0] refResult(input logic [15:0] a, input logic [15:0] b, input logic sm);
    if (sm) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Index of the MSB-first chunk holding the highest differing bit; NCHUNK when equal.
  function automatic int refFirstDiff(input logic [15:0] a, input logic [15:0] b);
    for (int p = NB - 1; p >= 0; p--)
      if (a[p] != b[p]) return (NB - 1 - p) / CW;
    return NCHUNK;
  endfunction

  function automatic int refLatency(input int fd);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    return (fd >= NCHUNK) ? NCHUNK : fd + 1;
`else
    return (fd >= 0) ? NCHUNK : NCHUNK;
`endif
  endfunction

  // Counts busy cycles from the current negedge until done is seen (bounded).
  task automatic waitDone(inout int lat, output bit timedOut);
    timedOut = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (busy) lat++;
      @(negedge clk);
    end
    if (!done) timedOut = 1'b1;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sm,
                               output int lat, output bit timedOut);
    @(negedge clk);
    A = a; B = b; sign_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    waitDone(lat, timedOut);
  endtask

  task automatic runCase(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic sm, input logic [2:0] expRes, input int expLat);
    int lat;
    bit timedOut;
    applyStimulus(a, b, sm, lat, timedOut);
    checkOutput({name, " timeout"}, int'(timedOut), 0);
    checkOutput({name, " result"}, int'({G, E, L}), int'(expRes));
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " busy in done"}, int'(busy), 0);
    @(negedge clk);
    checkOutput({name, " done pulse width"}, int'(done), 0);
    checkOutput({name, " result held"}, int'({G, E, L}), int'(expRes));
  endtask

  initial begin
    int lat;
    bit timedOut;
    int doneSeen;
    logic [15:0] ra, rb;
    logic rsm;

    vecs[0] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 0};
    vecs[1] = '{16'h8000, 16'h0001, 1'b1, 3'b001, 0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 3'b100, 0};
    vecs[3] = '{16'hBEEF, 16'hBEEF, 1'b0, 3'b010, 4};
    vecs[4] = '{16'h1235, 16'h1234, 1'b0, 3'b100, 3};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 3'b100, 0};
    vecs[6] = '{16'h1234, 16'h1244, 1'b0, 3'b001, 2};
    vecs[7] = '{16'hBEEF, 16'hBEEF, 1'b1, 3'b010, 4};

    // Reset with start held high: nothing may start.
    start = 1'b1; A = 16'h8000; B = 16'h7FFF; sign_mode = 1'b0;
    #12;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset GEL", int'({G, E, L}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("first start accepted", int'(busy), 1);
    lat = 0;
    waitDone(lat, timedOut);
    checkOutput("first op timeout", int'(timedOut), 0);
    checkOutput("first op result", int'({G, E, L}), 3'b100);
    checkOutput("first op latency", lat, refLatency(0));

    foreach (vecs[i])
      runCase($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res,
              refLatency(vecs[i].fd));

    // Start pulsed mid-RUN with different operands must be ignored.
    @(negedge clk);
    A = 16'h1235; B = 16'h1234; sign_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 16'h0000; B = 16'hFFFF; start = 1'b1;
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, timedOut);
    checkOutput("midrun timeout", int'(timedOut), 0);
    checkOutput("midrun result", int'({G, E, L}), 3'b100);
    checkOutput("midrun latency", lat, refLatency(3));

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    applyStimulus(16'h8000, 16'h7FFF, 1'b0, lat, timedOut);
    checkOutput("b2b first result", int'({G, E, L}), 3'b100);
    A = 16'h8000; B = 16'h0001; sign_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b busy next", int'(busy), 1);
    checkOutput("b2b GEL cleared", int'({G, E, L}), 0);
    lat = 0;
    waitDone(lat, timedOut);
    checkOutput("b2b timeout", int'(timedOut), 0);
    checkOutput("b2b second result", int'({G, E, L}), 3'b001);
    checkOutput("b2b second latency", lat, refLatency(0));

    // Reset after two busy cycles aborts without a done pulse.
    @(negedge clk);
    A = 16'hBEEF; B = 16'hBEEF; sign_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun reset busy", int'(busy), 0);
    checkOutput("midrun reset done", int'(done), 0);
    checkOutput("midrun reset GEL", int'({G, E, L}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("no done after abort", doneSeen, 0);
    runCase("after abort", 16'h1235, 16'h1234, 1'b0, 3'b100, refLatency(3));

    // Random operations: mix of random, equal and single-bit-difference pairs.
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'h0001 << $urandom_range(0, 15));
      endcase
      rsm = 1'($urandom_range(0, 1));
      runCase($sformatf("rand%0d", i), ra, rb, rsm, refResult(ra, rb, rsm),
              refLatency(refFirstDiff(ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
